adc_byte_packetizer: RTL and testbench



---
 rtl/adc_byte_packetizer.sv | 170 +++++++++++++++++
 tb/tb_adc_byte_packetizer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_byte_packetizer.sv
// adc_byte_packetizer
//   Pops bytes from a standard (non-FWFT) FIFO read port and frames them as
//   SYNC0, SYNC1, seq[15:8], seq[7:0], PAYLOAD_LEN payload bytes, checksum.
//   The checksum is the mod-256 sum of both sequence bytes and every payload
//   byte. Output is a byte-wide valid/ready stream.
//
// Ports
//   clk, rst_n     : FIFO read clock, asynchronous active-low reset
//   enable         : permits starting new packets (sampled in IDLE/DONE)
//   fifo_dout      : FIFO read data, valid one clk after fifo_rd_en
//   fifo_empty     : FIFO empty flag
//   fifo_rst_busy  : FIFO read-side reset busy, no reads while high
//   fifo_rd_en     : FIFO pop strobe (combinational, PAYLOAD state only)
//   m_data/m_valid/m_last/m_ready : output stream, m_last marks the checksum
//   pkt_count      : packets fully transmitted, wraps
//   busy           : high whenever the FSM is not idle
module adc_byte_packetizer #(
  parameter int unsigned PAYLOAD_LEN = 64,
  parameter logic [7:0]  SYNC0       = 8'hA5,
  parameter logic [7:0]  SYNC1       = 8'h5A
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [7:0]  fifo_dout,
  input  logic        fifo_empty,
  input  logic        fifo_rst_busy,
  output logic        fifo_rd_en,
  output logic [7:0]  m_data,
  output logic        m_valid,
  output logic        m_last,
  input  logic        m_ready,
  output logic [15:0] pkt_count,
  output logic        busy
);

  localparam logic [15:0] LEN = 16'(PAYLOAD_LEN);

  typedef enum logic [2:0] {IDLE, HDR, PAYLOAD, CSUM, DONE} state_t;

  state_t      state, state_d;
  logic [1:0]  hdr_idx, hdr_idx_d;
  logic [7:0]  csum, csum_d;
  logic [15:0] seq, seq_d;
  logic [15:0] req_cnt, req_cnt_d;
  logic        rd_pend;
  logic [7:0]  data_d;
  logic        valid_d, last_d;
  logic [15:0] pkt_d;
  logic        free, xfer, start_ok;

  assign free     = !m_valid || m_ready;
  assign xfer     = m_valid && m_ready;
  assign start_ok = enable && !fifo_empty && !fifo_rst_busy;
  assign busy     = (state != IDLE);

  always_comb begin
    state_d    = state;
    hdr_idx_d  = hdr_idx;
    csum_d     = csum;
    seq_d      = seq;
    req_cnt_d  = req_cnt;
    data_d     = m_data;
    valid_d    = m_valid && !m_ready;
    last_d     = m_last;
    pkt_d      = pkt_count;
    fifo_rd_en = 1'b0;

    case (state)
      IDLE: begin
        if (start_ok) begin
          state_d   = HDR;
          hdr_idx_d = '0;
          csum_d    = '0;
        end
      end

      HDR: begin
        if (free) begin
          valid_d   = 1'b1;
          last_d    = 1'b0;
          hdr_idx_d = hdr_idx + 2'd1;
          case (hdr_idx)
            2'd0: data_d = SYNC0;
            2'd1: data_d = SYNC1;
            2'd2: begin
              data_d = seq[15:8];
              csum_d = csum + seq[15:8];
            end
            default: begin
              data_d    = seq[7:0];
              csum_d    = csum + seq[7:0];
              state_d   = PAYLOAD;
              req_cnt_d = '0;
            end
          endcase
        end
      end

      PAYLOAD: begin
        // A pop is only issued when the output register will be empty by the
        // time its data returns, so the returning byte never overwrites a
        // stalled one.
        fifo_rd_en = !fifo_empty && !fifo_rst_busy && !rd_pend &&
                     (req_cnt < LEN) && free;
        if (fifo_rd_en) begin
          req_cnt_d = req_cnt + 16'd1;
        end
        if (rd_pend) begin
          data_d  = fifo_dout;
          valid_d = 1'b1;
          csum_d  = csum + fifo_dout;
          // req_cnt already counts the byte arriving now
          if (req_cnt == LEN) begin
            state_d = CSUM;
          end
        end
      end

      CSUM: begin
        if (free) begin
          data_d  = csum;
          last_d  = 1'b1;
          valid_d = 1'b1;
          state_d = DONE;
        end
      end

      DONE: begin
        if (xfer) begin
          last_d    = 1'b0;
          seq_d     = seq + 16'd1;
          pkt_d     = pkt_count + 16'd1;
          hdr_idx_d = '0;
          csum_d    = '0;
          state_d   = start_ok ? HDR : IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hdr_idx   <= '0;
      csum      <= '0;
      seq       <= '0;
      req_cnt   <= '0;
      rd_pend   <= 1'b0;
      m_data    <= '0;
      m_valid   <= 1'b0;
      m_last    <= 1'b0;
      pkt_count <= '0;
    end else begin
      state     <= state_d;
      hdr_idx   <= hdr_idx_d;
      csum      <= csum_d;
      seq       <= seq_d;
      req_cnt   <= req_cnt_d;
      rd_pend   <= fifo_rd_en;
      m_data    <= data_d;
      m_valid   <= valid_d;
      m_last    <= last_d;
      pkt_count <= pkt_d;
    end
  end

endmodule

// File: tb/tb_adc_byte_packetizer.sv
// Testbench for adc_byte_packetizer (PAYLOAD_LEN=4). A non-FWFT FIFO model
// feeds the DUT; a monitor records every transferred byte, pop strobes and
// output-hold behaviour; expected streams come from a packet-level model.
module tb_adc_byte_packetizer;

  localparam int LEN = 4;
  localparam int PKT = LEN + 5;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        enable = 1'b0;
  logic [7:0]  fifo_dout = 8'h00;
  logic        fifo_empty = 1'b1;
  logic        fifo_rst_busy = 1'b0;
  logic        fifo_rd_en;
  logic [7:0]  m_data;
  logic        m_valid;
  logic        m_last;
  logic        m_ready = 1'b1;
  logic [15:0] pkt_count;
  logic        busy;

  int total = 0;
  int bad = 0;

  bit ready_rand = 1'b0;
  bit rstb_rand = 1'b0;

  // FIFO storage: tasks append at avail, the FIFO model consumes at rd_ptr
  logic [7:0] src[0:1023];
  int avail = 0;
  int rd_ptr = 0;
  bit pop_pend = 1'b0;

  int rd_cnt = 0;
  int rd_viol = 0;
  int stall_viol = 0;
  bit have_stall = 1'b0;
  logic [7:0] st_d;
  logic st_l;

  logic [7:0] cap_d[$];
  logic       cap_l[$];

  logic [15:0] exp_seq = 16'h0000;
  logic [15:0] exp_pkts = 16'h0000;
  bq_t model_fifo;

  adc_byte_packetizer #(.PAYLOAD_LEN(LEN)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .fifo_dout(fifo_dout),
    .fifo_empty(fifo_empty),
    .fifo_rst_busy(fifo_rst_busy),
    .fifo_rd_en(fifo_rd_en),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_last(m_last),
    .m_ready(m_ready),
    .pkt_count(pkt_count),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // Input drivers and FIFO read port, updated just after each rising edge
  always @(posedge clk) begin
    #1;
    if (pop_pend) begin
      fifo_dout = src[rd_ptr];
      rd_ptr = rd_ptr + 1;
    end
    fifo_empty = (rd_ptr >= avail);
    m_ready = ready_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    fifo_rst_busy = rstb_rand ? ($urandom_range(0, 3) == 0) : 1'b0;
  end

  // Monitor: inputs and outputs are stable from here to the next rising edge
  always @(negedge clk) begin
    if (!rst_n) begin
      have_stall = 1'b0;
      pop_pend = 1'b0;
    end else begin
      if (have_stall && (!m_valid || m_data !== st_d || m_last !== st_l))
        stall_viol = stall_viol + 1;
      if (m_valid && !m_ready) begin
        have_stall = 1'b1;
        st_d = m_data;
        st_l = m_last;
      end else begin
        have_stall = 1'b0;
      end
      if (m_valid && m_ready) begin
        cap_d.push_back(m_data);
        cap_l.push_back(m_last);
      end
      pop_pend = fifo_rd_en;
      if (fifo_rd_en) begin
        rd_cnt = rd_cnt + 1;
        if (fifo_empty || fifo_rst_busy) rd_viol = rd_viol + 1;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    src[avail] = b;
    avail = avail + 1;
    model_fifo.push_back(b);
  endtask

  // Packet-level reference: frames n packets from the modelled FIFO contents
  task automatic expect_pkts(input int n, output bq_t ex);
    logic [7:0] sum;
    logic [7:0] b;
    ex = {};
    for (int p = 0; p < n; p++) begin
      sum = exp_seq[15:8] + exp_seq[7:0];
      ex.push_back(8'hA5);
      ex.push_back(8'h5A);
      ex.push_back(exp_seq[15:8]);
      ex.push_back(exp_seq[7:0]);
      for (int k = 0; k < LEN; k++) begin
        b = model_fifo.pop_front();
        sum = sum + b;
        ex.push_back(b);
      end
      ex.push_back(sum);
      exp_seq = exp_seq + 16'd1;
      exp_pkts = exp_pkts + 16'd1;
    end
  endtask

  task automatic wait_bytes(input int base, input int n, output bit to);
    int c;
    c = 0;
    to = 1'b0;
    while (cap_d.size() < base + n) begin
      @(negedge clk);
      c++;
      if (c > 4000) begin
        to = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    total += 6;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%b exp=0", m_valid); end
    if (m_last !== 1'b0) begin bad++; $display("FAIL reset_m_last got=%b exp=0", m_last); end
    if (m_data !== 8'h00) begin bad++; $display("FAIL reset_m_data got=%h exp=00", m_data); end
    if (pkt_count !== 16'h0000) begin bad++; $display("FAIL reset_pkt_count got=%h exp=0000", pkt_count); end
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL reset_rd_en got=%b exp=0", fifo_rd_en); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL idle_empty_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    bq_t ex;
    bit to;
    int base, rd0;
    base = cap_d.size();
    rd0 = rd_cnt;
    ready_rand = 1'b0;
    for (int i = 1; i <= 4; i++) push_byte(8'(i));
    expect_pkts(1, ex);
    enable = 1'b1;
    wait_bytes(base, ex.size(), to);
    repeat (3) @(negedge clk);
    total++;
    if (to) begin bad++; $display("FAIL basic_timeout got=%0d need=%0d", cap_d.size() - base, ex.size()); end
    for (int i = 0; i < ex.size(); i++) begin
      logic [8:0] got, want;
      got = 'x;
      if (base + i < cap_d.size()) got = {cap_l[base + i], cap_d[base + i]};
      want = {(i % PKT == PKT - 1), ex[i]};
      total++;
      if (got !== want) begin bad++; $display("FAIL basic_byte%0d got=%h exp=%h", i, got, want); end
    end
    total += 3;
    if (pkt_count !== exp_pkts) begin bad++; $display("FAIL basic_pkt_count got=%h exp=%h", pkt_count, exp_pkts); end
    if (rd_cnt - rd0 !== 4) begin bad++; $display("FAIL basic_rd_pulses got=%0d exp=4", rd_cnt - rd0); end
    if (busy !== 1'b0) begin bad++; $display("FAIL basic_busy got=%b exp=0", busy); end
  endtask

  task automatic test_backpressure();
    bq_t ex;
    bit to;
    int base, rd0, sv0;
    base = cap_d.size();
    rd0 = rd_cnt;
    sv0 = stall_viol;
    ready_rand = 1'b1;
    for (int i = 0; i < LEN; i++) push_byte(8'($urandom));
    expect_pkts(1, ex);
    wait_bytes(base, ex.size(), to);
    ready_rand = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (to) begin bad++; $display("FAIL bp_timeout got=%0d need=%0d", cap_d.size() - base, ex.size()); end
    for (int i = 0; i < ex.size(); i++) begin
      logic [8:0] got, want;
      got = 'x;
      if (base + i < cap_d.size()) got = {cap_l[base + i], cap_d[base + i]};
      want = {(i % PKT == PKT - 1), ex[i]};
      total++;
      if (got !== want) begin bad++; $display("FAIL bp_byte%0d got=%h exp=%h", i, got, want); end
    end
    total += 3;
    if (stall_viol - sv0 !== 0) begin bad++; $display("FAIL bp_hold_stable got=%0d exp=0", stall_viol - sv0); end
    if (rd_cnt - rd0 !== 4) begin bad++; $display("FAIL bp_rd_pulses got=%0d exp=4", rd_cnt - rd0); end
    if (pkt_count !== exp_pkts) begin bad++; $display("FAIL bp_pkt_count got=%h exp=%h", pkt_count, exp_pkts); end
  endtask

  task automatic test_empty_stall();
    bq_t ex;
    bit to;
    int base, rd0;
    base = cap_d.size();
    rd0 = rd_cnt;
    for (int i = 0; i < LEN; i++) push_byte(8'($urandom));
    avail = avail - 2;  // hold back the last two bytes
    expect_pkts(1, ex);
    wait_bytes(base, 6, to);
    repeat (20) @(negedge clk);
    total += 4;
    if (to) begin bad++; $display("FAIL stall_first_timeout got=%0d need=6", cap_d.size() - base); end
    if (cap_d.size() - base !== 6) begin bad++; $display("FAIL stall_byte_count got=%0d exp=6", cap_d.size() - base); end
    if (rd_cnt - rd0 !== 2) begin bad++; $display("FAIL stall_rd_pulses got=%0d exp=2", rd_cnt - rd0); end
    if (busy !== 1'b1) begin bad++; $display("FAIL stall_busy got=%b exp=1", busy); end
    avail = avail + 2;
    wait_bytes(base, ex.size(), to);
    repeat (3) @(negedge clk);
    total++;
    if (to) begin bad++; $display("FAIL stall_timeout got=%0d need=%0d", cap_d.size() - base, ex.size()); end
    for (int i = 0; i < ex.size(); i++) begin
      logic [8:0] got, want;
      got = 'x;
      if (base + i < cap_d.size()) got = {cap_l[base + i], cap_d[base + i]};
      want = {(i % PKT == PKT - 1), ex[i]};
      total++;
      if (got !== want) begin bad++; $display("FAIL stall_byte%0d got=%h exp=%h", i, got, want); end
    end
    total++;
    if (rd_viol !== 0) begin bad++; $display("FAIL stall_rd_while_empty got=%0d exp=0", rd_viol); end
  endtask

  task automatic test_back_to_back();
    bq_t ex;
    bit to;
    int base, rd0, sv0;
    base = cap_d.size();
    rd0 = rd_cnt;
    sv0 = stall_viol;
    ready_rand = 1'b1;
    rstb_rand = 1'b1;
    for (int i = 0; i < 3 * LEN; i++) push_byte(8'($urandom));
    expect_pkts(3, ex);
    wait_bytes(base, ex.size(), to);
    ready_rand = 1'b0;
    rstb_rand = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (to) begin bad++; $display("FAIL b2b_timeout got=%0d need=%0d", cap_d.size() - base, ex.size()); end
    for (int i = 0; i < ex.size(); i++) begin
      logic [8:0] got, want;
      got = 'x;
      if (base + i < cap_d.size()) got = {cap_l[base + i], cap_d[base + i]};
      want = {(i % PKT == PKT - 1), ex[i]};
      total++;
      if (got !== want) begin bad++; $display("FAIL b2b_byte%0d got=%h exp=%h", i, got, want); end
    end
    total += 4;
    if (pkt_count !== exp_pkts) begin bad++; $display("FAIL b2b_pkt_count got=%h exp=%h", pkt_count, exp_pkts); end
    if (rd_cnt - rd0 !== 12) begin bad++; $display("FAIL b2b_rd_pulses got=%0d exp=12", rd_cnt - rd0); end
    if (rd_viol !== 0) begin bad++; $display("FAIL b2b_rd_while_busy got=%0d exp=0", rd_viol); end
    if (stall_viol - sv0 !== 0) begin bad++; $display("FAIL b2b_hold_stable got=%0d exp=0", stall_viol - sv0); end
  endtask

  task automatic test_seq_wrap();
    bq_t ex;
    bit to;
    int base;
    @(negedge clk);
    force dut.seq = 16'hFFFF;
    force dut.pkt_count = 16'hFFFF;
    @(negedge clk);
    release dut.seq;
    release dut.pkt_count;
    exp_seq = 16'hFFFF;
    exp_pkts = 16'hFFFF;
    base = cap_d.size();
    for (int i = 0; i < 2 * LEN; i++) push_byte(8'h00);
    expect_pkts(2, ex);
    wait_bytes(base, ex.size(), to);
    repeat (3) @(negedge clk);
    total++;
    if (to) begin bad++; $display("FAIL wrap_timeout got=%0d need=%0d", cap_d.size() - base, ex.size()); end
    for (int i = 0; i < ex.size(); i++) begin
      logic [8:0] got, want;
      got = 'x;
      if (base + i < cap_d.size()) got = {cap_l[base + i], cap_d[base + i]};
      want = {(i % PKT == PKT - 1), ex[i]};
      total++;
      if (got !== want) begin bad++; $display("FAIL wrap_byte%0d got=%h exp=%h", i, got, want); end
    end
    total++;
    if (pkt_count !== exp_pkts) begin bad++; $display("FAIL wrap_pkt_count got=%h exp=%h", pkt_count, exp_pkts); end
  endtask

  task automatic test_enable_drop();
    bq_t ex;
    bit to;
    int base, rd0, c;
    base = cap_d.size();
    rd0 = rd_cnt;
    for (int i = 0; i < 2 * LEN; i++) push_byte(8'($urandom));
    expect_pkts(1, ex);
    wait_bytes(base, 5, to);
    enable = 1'b0;
    wait_bytes(base, ex.size(), to);
    c = 0;
    while (busy && c < 100) begin @(negedge clk); c++; end
    repeat (30) @(negedge clk);
    total++;
    if (to) begin bad++; $display("FAIL endrop_timeout got=%0d need=%0d", cap_d.size() - base, ex.size()); end
    for (int i = 0; i < ex.size(); i++) begin
      logic [8:0] got, want;
      got = 'x;
      if (base + i < cap_d.size()) got = {cap_l[base + i], cap_d[base + i]};
      want = {(i % PKT == PKT - 1), ex[i]};
      total++;
      if (got !== want) begin bad++; $display("FAIL endrop_byte%0d got=%h exp=%h", i, got, want); end
    end
    total += 4;
    if (cap_d.size() - base !== PKT) begin bad++; $display("FAIL endrop_extra_bytes got=%0d exp=%0d", cap_d.size() - base, PKT); end
    if (busy !== 1'b0) begin bad++; $display("FAIL endrop_busy got=%b exp=0", busy); end
    if (rd_cnt - rd0 !== 4) begin bad++; $display("FAIL endrop_rd_pulses got=%0d exp=4", rd_cnt - rd0); end
    if (pkt_count !== exp_pkts) begin bad++; $display("FAIL endrop_pkt_count got=%h exp=%h", pkt_count, exp_pkts); end
  endtask

  task automatic test_reset_mid();
    bq_t ex;
    bit to;
    int base, npk;
    base = cap_d.size();
    for (int i = 0; i < LEN; i++) push_byte(8'($urandom));
    enable = 1'b1;
    wait_bytes(base, 3, to);
    total++;
    if (to) begin bad++; $display("FAIL rstmid_hdr_timeout got=%0d need=3", cap_d.size() - base); end
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total += 4;
    if (m_valid !== 1'b0) begin bad++; $display("FAIL rstmid_m_valid got=%b exp=0", m_valid); end
    if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rstmid_rd_en got=%b exp=0", fifo_rd_en); end
    if (busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    if (pkt_count !== 16'h0000) begin bad++; $display("FAIL rstmid_pkt_count got=%h exp=0000", pkt_count); end
    repeat (3) @(negedge clk);
    // Bytes popped before reset are gone; rebuild the model from what is left
    exp_seq = 16'h0000;
    exp_pkts = 16'h0000;
    model_fifo = {};
    for (int i = rd_ptr; i < avail; i++) model_fifo.push_back(src[i]);
    while (model_fifo.size() == 0 || model_fifo.size() % LEN != 0) push_byte(8'($urandom));
    npk = model_fifo.size() / LEN;
    expect_pkts(npk, ex);
    base = cap_d.size();
    rst_n = 1'b1;
    wait_bytes(base, ex.size(), to);
    repeat (3) @(negedge clk);
    total++;
    if (to) begin bad++; $display("FAIL rstmid_timeout got=%0d need=%0d", cap_d.size() - base, ex.size()); end
    for (int i = 0; i < ex.size(); i++) begin
      logic [8:0] got, want;
      got = 'x;
      if (base + i < cap_d.size()) got = {cap_l[base + i], cap_d[base + i]};
      want = {(i % PKT == PKT - 1), ex[i]};
      total++;
      if (got !== want) begin bad++; $display("FAIL rstmid_byte%0d got=%h exp=%h", i, got, want); end
    end
    total++;
    if (pkt_count !== exp_pkts) begin bad++; $display("FAIL rstmid_pkt_count got=%h exp=%h", pkt_count, exp_pkts); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_empty_stall();
    test_back_to_back();
    test_seq_wrap();
    test_enable_drop();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
